seg7_display: RTL and testbench

Memory-mapped eight-digit seven-segment display controller on the CPU's peripheral bus, alongside the timer. Software writes a 32-bit value, typically a timer count it has read, and the block shows it as eight hex digits. A prescaler and digit counter scan one digit at a time through active-low anode and segment outputs. A shadow copy of the value is taken only at scan wrap, so a frame never shows digits from two different writes.

---
 rtl/seg7_display.sv | 129 ++++++++++++
 tb/tb_seg7_display.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_display.sv
// Bus-mapped eight-digit hex seven-segment scanner with frame-aligned shadow copy.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_display #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
  parameter int unsigned SCAN_DIV  = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  dig_n,
  output logic [7:0]  seg_n
);

  typedef enum logic [2:0] {
    DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
  } digit_e;

  localparam logic [19:0] PRE_LAST = 20'(SCAN_DIV - 1);

  logic        w_match;
  logic        w_selData;
  logic        w_selCtrl;
  logic [31:0] r_data;
  logic        r_on;
  logic [7:0]  r_mask;
  logic [19:0] r_pre;
  logic        w_tick;
  digit_e      r_idx;
  logic [31:0] r_shd;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic        w_show;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_match   = (addr[31:3] == BASE_ADDR[31:3]);
  assign w_selData = w_match && !addr[2];
  assign w_selCtrl = w_match && addr[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 32'd0;
      r_on   <= 1'b1;
      r_mask <= 8'hFF;
    end else begin
      if (we && w_selData) begin
        r_data <= wdata;
      end
      if (we && w_selCtrl) begin
        r_on   <= wdata[0];
        r_mask <= wdata[15:8];
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (w_selData) begin
      rdata = r_data;
    end else if (w_selCtrl) begin
      rdata = {16'd0, r_mask, 7'd0, r_on};
    end
  end

  assign w_tick = (r_pre == PRE_LAST);
  assign w_nib  = r_shd[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  logic [31:0] w_upper;
  assign w_upper = r_shd >> {r_idx, 2'b00};
  assign w_blank = (r_idx != DIG0) && (w_upper == 32'd0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_show = r_on && r_mask[r_idx] && !w_blank;

  // Shadow reloads only on the 7->0 wrap so a frame never mixes two writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= 20'd0;
      r_idx <= DIG0;
      r_shd <= 32'd0;
      dig_n <= 8'hFF;
      seg_n <= 8'hFF;
    end else begin
      if (w_tick) begin
        r_pre <= 20'd0;
        r_idx <= digit_e'(r_idx + 3'd1);
        if (r_idx == DIG7) begin
          r_shd <= r_data;
        end
      end else begin
        r_pre <= r_pre + 20'd1;
      end
      if (w_show) begin
        dig_n <= ~(8'b1 << r_idx);
        seg_n <= {1'b1, hex7(w_nib)};
      end else begin
        dig_n <= 8'hFF;
        seg_n <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_display.sv
// Directed bench for seg7_display with SCAN_DIV=4 (one frame = 32 cycles).
// Expectations follow the SEG7_LEADING_ZERO_BLANK_EN build setting.
module tb_seg7_display;

  localparam logic [31:0] BASE = 32'hFFFF_F000;
  localparam logic [63:0] WALK   = 64'h7FBF_DFEF_F7FB_FDFE;
  localparam logic [63:0] S1234  = 64'hF9A4_B099_8883_C6A1;
  localparam logic [63:0] SALL_E = 64'h8E8E_8E8E_8E8E_8E8E;
  localparam logic [63:0] MSEG   = 64'hFFFF_FFFF_8E8E_8E8E;
  localparam logic [63:0] MDIG   = 64'hFFFF_FFFF_F7FB_FDFE;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [63:0] ZSEG  = 64'hFFFF_FFFF_FFFF_FFC0;
  localparam logic [63:0] ZDIG  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] A0SEG = 64'hFFFF_FFFF_FFFF_88C0;
  localparam logic [63:0] A0DIG = 64'hFFFF_FFFF_FFFF_FDFE;
`else
  localparam logic [63:0] ZSEG  = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] ZDIG  = WALK;
  localparam logic [63:0] A0SEG = 64'hC0C0_C0C0_C0C0_88C0;
  localparam logic [63:0] A0DIG = WALK;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [7:0]  dig_n;
  logic [7:0]  seg_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seg7_display #(.BASE_ADDR(BASE), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .dig_n (dig_n),
    .seg_n (seg_n)
  );

  always #5 clk = ~clk;

  // Reference cycle count since reset release; slot of digit d in frame f is 32f+4d+1..+4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic readReg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    checkOutput(tag, rdata, exp);
  endtask

  task automatic checkFrame(input int f, input logic [63:0] segs, input logic [63:0] digs,
                            input int lo, input int hi);
    for (int d = lo; d <= hi; d++) begin
      for (int j = 1; j <= 4; j++) begin
        waitCycle(32 * f + 4 * d + j);
        checkOutput($sformatf("f%0d_d%0d_c%0d_dig", f, d, j), {24'd0, dig_n}, {24'd0, digs[8*d +: 8]});
        checkOutput($sformatf("f%0d_d%0d_c%0d_seg", f, d, j), {24'd0, seg_n}, {24'd0, segs[8*d +: 8]});
      end
    end
  endtask

  initial begin
    // Reset state and register reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_dig", {24'd0, dig_n}, 32'h0000_00FF);
    checkOutput("rst_seg", {24'd0, seg_n}, 32'h0000_00FF);
    readReg("rst_ctrl", BASE + 32'd4, 32'h0000_FF01);
    readReg("rst_data", BASE, 32'd0);
    readReg("rst_idle", 32'd0, 32'd0);
    rst = 1'b0;
    waitCycle(2);
    checkOutput("post_rst_dig", {24'd0, dig_n}, 32'h0000_00FE);
    checkOutput("post_rst_seg", {24'd0, seg_n}, 32'h0000_00C0);

    // Basic write: old shadow holds until wrap, next frame scans 1234ABCD.
    applyStimulus(BASE, 32'h1234_ABCD);
    readReg("data_rb", BASE, 32'h1234_ABCD);
    checkFrame(0, ZSEG, ZDIG, 1, 7);
    checkFrame(1, S1234, WALK, 0, 7);

    // Shadow: mid-frame write waits for wrap; wrap-cycle write lands a frame later.
    checkFrame(2, S1234, WALK, 0, 2);
    applyStimulus(BASE, 32'hFFFF_FFFF);
    checkFrame(2, S1234, WALK, 3, 7);
    checkFrame(3, SALL_E, WALK, 0, 2);
    applyStimulus(BASE, 32'h0000_0000);
    checkFrame(3, SALL_E, WALK, 3, 6);
    waitCycle(127);
    applyStimulus(BASE, 32'hFFFF_FFFF);
    readReg("data_rb2", BASE, 32'hFFFF_FFFF);
    checkFrame(4, ZSEG, ZDIG, 0, 7);
    checkFrame(5, SALL_E, WALK, 0, 7);

    // Mask upper digits, then switch display off.
    applyStimulus(BASE + 32'd4, 32'hFFFF_0F01);
    readReg("ctrl_rb", BASE + 32'd4, 32'h0000_0F01);
    checkFrame(7, MSEG, MDIG, 0, 7);
    applyStimulus(BASE + 32'd4, 32'd0);
    checkOutput("off_edge_dig", {24'd0, dig_n}, 32'h0000_00FE);
    checkOutput("off_edge_seg", {24'd0, seg_n}, 32'h0000_008E);
    for (int k = 258; k <= 265; k++) begin
      waitCycle(k);
      checkOutput($sformatf("off_c%0d_dig", k), {24'd0, dig_n}, 32'h0000_00FF);
      checkOutput($sformatf("off_c%0d_seg", k), {24'd0, seg_n}, 32'h0000_00FF);
    end
    readReg("ctrl_off_rb", BASE + 32'd4, 32'd0);

    // Leading-zero pattern.
    applyStimulus(BASE + 32'd4, 32'h0000_FF01);
    applyStimulus(BASE, 32'h0000_00A0);
    checkFrame(9, A0SEG, A0DIG, 0, 7);
    checkFrame(10, A0SEG, A0DIG, 0, 4);

    // Asynchronous reset during digit 5.
    waitCycle(342);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_dig", {24'd0, dig_n}, 32'h0000_00FF);
    checkOutput("mid_rst_seg", {24'd0, seg_n}, 32'h0000_00FF);
    @(negedge clk);
    readReg("mid_rst_data", BASE, 32'd0);
    readReg("mid_rst_ctrl", BASE + 32'd4, 32'h0000_FF01);
    rst = 1'b0;
    waitCycle(1);
    checkOutput("restart_dig", {24'd0, dig_n}, 32'h0000_00FE);
    checkOutput("restart_seg", {24'd0, seg_n}, 32'h0000_00C0);

    // Address decode: +8 is unmapped, low address bits are ignored.
    applyStimulus(BASE + 32'd8, 32'hDEAD_BEEF);
    readReg("unmap_rd", BASE + 32'd8, 32'd0);
    readReg("unmap_data", BASE, 32'd0);
    readReg("unmap_ctrl", BASE + 32'd4, 32'h0000_FF01);
    applyStimulus(BASE + 32'd3, 32'h5555_1234);
    readReg("lowbits_data", BASE, 32'h5555_1234);
    checkOutput("restart_dig3", {24'd0, dig_n}, 32'h0000_00FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
